// File: rtl/ysyx_lsu_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_lsu_axi_pkg
//  Purpose  : Shared types and helpers for the LSU-to-AXI4-Lite bridge.
//             - read / write FSM state encodings
//             - AXI response codes
//             - byte-mask to AXI size conversion
//             - response error classification
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_lsu_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2,
        R_DONE = 2'd3
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2,
        W_DONE = 2'd3
    } wstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Byte mask (right-justified) to AXI size; anything unexpected is
    // treated as a full word.
    function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
        case (strb)
            8'h01:   return 3'd0;
            8'h03:   return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    // Every response other than OKAY counts as an error, including EXOKAY,
    // which a single-beat non-exclusive access should never receive.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            RESP_OKAY:   return 1'b0;
            RESP_SLVERR: return 1'b1;
            RESP_DECERR: return 1'b1;
            default:     return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_lsu_axi_walign.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_lsu_axi_walign
//  Purpose  : Combinational store lane shifter. Moves right-justified store
//             data and byte strobes into the lanes selected by the low two
//             address bits.
//  Ports    : offset      in   address bits [1:0]
//             wdata       in   right-justified store data
//             wstrb       in   right-justified byte strobes
//             lane_wdata  out  lane-aligned store data
//             lane_wstrb  out  lane-aligned strobes (truncated to 4 bits)
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_lsu_axi_walign #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [3:0]      wstrb,
    output logic [XLEN-1:0] lane_wdata,
    output logic [3:0]      lane_wstrb
);

    // A halfword at offset 3 is not flagged; its upper byte simply falls off
    // the top of both the data and the strobe.
    always_comb begin
        lane_wdata = wdata << {offset, 3'b000};
        lane_wstrb = wstrb << offset;
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_lsu_axi
//  Purpose  : Bridges the LSU's level-held load/store requests to single-beat
//             32-bit AXI4-Lite transactions. Stores take priority over loads
//             and the two directions are never in flight together.
//  Ports    : clock, reset             clock, synchronous active-high reset
//             lsu_ar* / lsu_rstrb      load request from the LSU
//             bus_rdata, lsu_rvalid    raw load word and completion pulse
//             lsu_aw* / lsu_w*         store request from the LSU
//             lsu_wready               store completion pulse
//             m_ar* m_r* m_aw* m_w* m_b*  AXI4-Lite manager interface
//             bus_err                  sticky bus error (cleared by reset)
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_lsu_axi
    import ysyx_lsu_axi_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [XLEN-1:0] lsu_araddr,
    input  logic            lsu_arvalid,
    input  logic [7:0]      lsu_rstrb,
    output logic [XLEN-1:0] bus_rdata,
    output logic            lsu_rvalid,

    input  logic [XLEN-1:0] lsu_awaddr,
    input  logic            lsu_awvalid,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [7:0]      lsu_wstrb,
    input  logic            lsu_wvalid,
    output logic            lsu_wready,

    output logic [XLEN-1:0] m_araddr,
    output logic [2:0]      m_arsize,
    output logic            m_arvalid,
    input  logic            m_arready,

    input  logic [XLEN-1:0] m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rvalid,
    output logic            m_rready,

    output logic [XLEN-1:0] m_awaddr,
    output logic [2:0]      m_awsize,
    output logic            m_awvalid,
    input  logic            m_awready,

    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,

    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,

    output logic            bus_err
);

    rstate_t r_state, r_next;
    wstate_t w_state, w_next;

    logic            aw_done, w_done;
    logic            store_req;
    logic            rd_start, wr_start;
    logic [XLEN-1:0] lane_wdata;
    logic [3:0]      lane_wstrb;

    // Any hint of a store holds loads back, so a store presented in the same
    // cycle as a load (or later, while the load still waits) goes first.
    assign store_req = lsu_awvalid | lsu_wvalid;
    assign rd_start  = (r_state == R_IDLE) && (w_state == W_IDLE)
                       && lsu_arvalid && !store_req;
    assign wr_start  = (w_state == W_IDLE) && (r_state == R_IDLE)
                       && lsu_awvalid && lsu_wvalid;

    ysyx_lsu_axi_walign #(
        .XLEN (XLEN)
    ) u_walign (
        .offset     (lsu_awaddr[1:0]),
        .wdata      (lsu_wdata),
        .wstrb      (lsu_wstrb[3:0]),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb)
    );

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        r_next     = r_state;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        lsu_rvalid = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_start) r_next = R_AR;
            end
            R_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) r_next = R_R;
            end
            R_R: begin
                m_rready = 1'b1;
                if (m_rvalid) r_next = R_DONE;
            end
            R_DONE: begin
                lsu_rvalid = 1'b1;
                r_next     = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: next state and outputs. AW and W are independent; each
    // valid drops after its own handshake, tracked by aw_done / w_done.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = w_state;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        lsu_wready = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (wr_start) w_next = W_REQ;
            end
            W_REQ: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
                if ((aw_done || m_awready) && (w_done || m_wready))
                    w_next = W_B;
            end
            W_B: begin
                m_bready = 1'b1;
                if (m_bvalid) w_next = W_DONE;
            end
            W_DONE: begin
                lsu_wready = 1'b1;
                w_next     = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request fields, read data, handshake flags, sticky error.
    // Captured fields stay put for the whole transaction, so an LSU that
    // drops its request early still sees the access finish.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            m_araddr  <= '0;
            m_arsize  <= 3'd0;
            m_awaddr  <= '0;
            m_awsize  <= 3'd0;
            m_wdata   <= '0;
            m_wstrb   <= 4'd0;
            bus_rdata <= '0;
            bus_err   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (rd_start) begin
                m_araddr <= lsu_araddr;
                m_arsize <= strb_to_size(lsu_rstrb);
            end

            if ((r_state == R_R) && m_rvalid) begin
                bus_rdata <= m_rdata;
                if (resp_is_err(m_rresp)) bus_err <= 1'b1;
            end

            if (wr_start) begin
                m_awaddr <= lsu_awaddr;
                m_awsize <= strb_to_size(lsu_wstrb);
                m_wdata  <= lane_wdata;
                m_wstrb  <= lane_wstrb;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end else if (w_state == W_REQ) begin
                if (m_awvalid && m_awready) aw_done <= 1'b1;
                if (m_wvalid && m_wready)   w_done  <= 1'b1;
            end

            if ((w_state == W_B) && m_bvalid && resp_is_err(m_bresp))
                bus_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu_axi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_lsu_axi
//  Purpose  : Directed self-checking bench for ysyx_lsu_axi. A small AXI
//             slave model with programmable per-channel delays answers the
//             DUT; expected addresses, sizes, data and strobes are queued
//             when a request is issued and compared at each handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_lsu_axi;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } addr_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wdat_exp_t;

    logic        clock, reset;
    logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata, bus_rdata;
    logic        lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready;
    logic [7:0]  lsu_rstrb, lsu_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [2:0]  m_arsize, m_awsize;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;
    logic        bus_err;

    ysyx_lsu_axi #(.XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .lsu_araddr  (lsu_araddr),
        .lsu_arvalid (lsu_arvalid),
        .lsu_rstrb   (lsu_rstrb),
        .bus_rdata   (bus_rdata),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_awaddr  (lsu_awaddr),
        .lsu_awvalid (lsu_awvalid),
        .lsu_wdata   (lsu_wdata),
        .lsu_wstrb   (lsu_wstrb),
        .lsu_wvalid  (lsu_wvalid),
        .lsu_wready  (lsu_wready),
        .m_araddr    (m_araddr),
        .m_arsize    (m_arsize),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_awaddr    (m_awaddr),
        .m_awsize    (m_awsize),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .bus_err     (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int overlap    = 0;

    // Scoreboard queues
    addr_exp_t   ar_q[$];
    addr_exp_t   aw_q[$];
    wdat_exp_t   w_q[$];
    logic [31:0] rd_q[$];

    // Slave model configuration
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp, slv_bresp;
    bit          drop_r;

    // Per-run observations
    int rv_cyc, wr_cyc, b_cyc;
    int rv_pulses, wr_pulses, ar_hs, aw_hs, w_hs, b_hs;
    int ar_extra, aw_extra, w_extra, b_extra, idle_bad;

    // Reads and writes must never be on the bus together.
    always @(negedge clock) begin
        if (!reset && (m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready))
            overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs the slave model until every requested completion pulse has been
    // seen (or the cycle budget expires), then idles a few cycles.
    task automatic run_bus(input string name, input bit want_r, input bit want_w);
        int ar_wait, r_wait, aw_wait, w_wait, b_wait, c;
        bit ar_g, r_g, aw_g, w_g, b_g, r_fin, w_fin;
        addr_exp_t ea;
        wdat_exp_t ew;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; c = 0;
        ar_g = 0; r_g = 0; aw_g = 0; w_g = 0; b_g = 0;
        r_fin = !want_r; w_fin = !want_w;
        rv_cyc = -1; wr_cyc = -1; b_cyc = -1;
        rv_pulses = 0; wr_pulses = 0; ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_extra = 0; aw_extra = 0; w_extra = 0; b_extra = 0; idle_bad = 0;
        while (!(r_fin && w_fin) && c < 200) begin
            @(negedge clock);
            c++;
            if (drop_r && c == 2) lsu_arvalid = 1'b0;
            if (lsu_rvalid) begin
                rv_pulses++;
                if (rv_cyc < 0) rv_cyc = c;
                lsu_arvalid = 1'b0;
                r_fin = 1'b1;
                chk({name, "_rd_q_level"}, 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) chk({name, "_rdata"}, bus_rdata, rd_q.pop_front());
            end
            if (lsu_wready) begin
                wr_pulses++;
                if (wr_cyc < 0) wr_cyc = c;
                lsu_awvalid = 1'b0;
                lsu_wvalid  = 1'b0;
                w_fin = 1'b1;
            end
            // AR channel
            m_arready = 1'b0;
            if (m_arvalid && ar_g) ar_extra++;
            else if (m_arvalid) begin
                if (ar_wait == ar_dly) begin
                    m_arready = 1'b1; ar_g = 1'b1; ar_hs++;
                    chk({name, "_ar_q_level"}, 32'(ar_q.size() != 0), 32'd1);
                    if (ar_q.size() != 0) begin
                        ea = ar_q.pop_front();
                        chk({name, "_araddr"}, m_araddr, ea.addr);
                        chk({name, "_arsize"}, 32'(m_arsize), 32'(ea.size));
                    end
                end else ar_wait++;
            end
            // R channel
            m_rvalid = 1'b0;
            if (ar_g && !r_g && m_rready) begin
                if (r_wait == r_dly) begin
                    m_rvalid = 1'b1; m_rdata = slv_rdata; m_rresp = slv_rresp; r_g = 1'b1;
                end else r_wait++;
            end
            // AW channel
            m_awready = 1'b0;
            if (m_awvalid && aw_g) aw_extra++;
            else if (m_awvalid) begin
                if (aw_wait == aw_dly) begin
                    m_awready = 1'b1; aw_g = 1'b1; aw_hs++;
                    chk({name, "_aw_q_level"}, 32'(aw_q.size() != 0), 32'd1);
                    if (aw_q.size() != 0) begin
                        ea = aw_q.pop_front();
                        chk({name, "_awaddr"}, m_awaddr, ea.addr);
                        chk({name, "_awsize"}, 32'(m_awsize), 32'(ea.size));
                    end
                end else aw_wait++;
            end
            // W channel
            m_wready = 1'b0;
            if (m_wvalid && w_g) w_extra++;
            else if (m_wvalid) begin
                if (w_wait == w_dly) begin
                    m_wready = 1'b1; w_g = 1'b1; w_hs++;
                    chk({name, "_w_q_level"}, 32'(w_q.size() != 0), 32'd1);
                    if (w_q.size() != 0) begin
                        ew = w_q.pop_front();
                        chk({name, "_wdata"}, m_wdata, ew.data);
                        chk({name, "_wstrb"}, 32'(m_wstrb), 32'(ew.strb));
                    end
                end else w_wait++;
            end
            // B channel
            m_bvalid = 1'b0;
            if (m_bready && b_g) b_extra++;
            else if (aw_g && w_g && m_bready) begin
                if (b_wait == b_dly) begin
                    m_bvalid = 1'b1; m_bresp = slv_bresp; b_g = 1'b1; b_hs++; b_cyc = c;
                end else b_wait++;
            end
        end
        chk({name, "_completed"}, 32'(r_fin && w_fin), 32'd1);
        m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        drop_r = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (lsu_rvalid) rv_pulses++;
            if (lsu_wready) wr_pulses++;
            if (m_arvalid || m_awvalid || m_wvalid || m_rready || m_bready) idle_bad++;
        end
        chk({name, "_idle_after"}, 32'(idle_bad), 32'd0);
        if (want_r) begin
            chk({name, "_rvalid_pulses"}, 32'(rv_pulses), 32'd1);
            chk({name, "_ar_handshakes"}, 32'(ar_hs), 32'd1);
            chk({name, "_ar_extra"}, 32'(ar_extra), 32'd0);
        end
        if (want_w) begin
            chk({name, "_wready_pulses"}, 32'(wr_pulses), 32'd1);
            chk({name, "_aw_handshakes"}, 32'(aw_hs), 32'd1);
            chk({name, "_w_handshakes"}, 32'(w_hs), 32'd1);
            chk({name, "_aw_extra"}, 32'(aw_extra), 32'd0);
            chk({name, "_w_extra"}, 32'(w_extra), 32'd0);
            chk({name, "_b_extra"}, 32'(b_extra), 32'd0);
            chk({name, "_wready_after_b"}, 32'(wr_cyc), 32'(b_cyc + 1));
        end
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [7:0] strb,
                            input logic [2:0] size, input logic [31:0] rdata);
        lsu_araddr  = addr;
        lsu_rstrb   = strb;
        lsu_arvalid = 1'b1;
        slv_rdata   = rdata;
        ar_q.push_back('{addr: addr, size: size});
        rd_q.push_back(rdata);
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] strb, input logic [2:0] size,
                             input logic [31:0] exp_data, input logic [3:0] exp_strb);
        lsu_awaddr  = addr;
        lsu_wdata   = data;
        lsu_wstrb   = strb;
        lsu_awvalid = 1'b1;
        lsu_wvalid  = 1'b1;
        aw_q.push_back('{addr: addr, size: size});
        w_q.push_back('{data: exp_data, strb: exp_strb});
    endtask

    initial begin
        bit saw_rr;
        reset = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        slv_rdata = '0; slv_rresp = 2'd0; slv_bresp = 2'd0; drop_r = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        chk("reset_ctl", {24'd0, m_arvalid, m_rready, m_awvalid, m_wvalid,
                          m_bready, lsu_rvalid, lsu_wready, bus_err}, 32'd0);
        chk("reset_rdata", bus_rdata, 32'd0);

        // LW with delayed AR and R
        ar_dly = 2; r_dly = 2; slv_rresp = 2'd0;
        set_load(32'h8000_0000, 8'h0f, 3'd2, 32'hDEAD_BEEF);
        run_bus("lw", 1'b1, 1'b0);
        chk("lw_rdata_hold", bus_rdata, 32'hDEAD_BEEF);

        // SB at offset 3
        aw_dly = 1; w_dly = 1; b_dly = 1; slv_bresp = 2'd0;
        set_store(32'h8000_0003, 32'h0000_00AB, 8'h01, 3'd0, 32'hAB00_0000, 4'h8);
        run_bus("sb", 1'b0, 1'b1);

        // SH at offset 2, W accepted two cycles before AW
        aw_dly = 2; w_dly = 0; b_dly = 0;
        set_store(32'h0F00_0002, 32'h0000_1234, 8'h03, 3'd1, 32'h1234_0000, 4'hC);
        run_bus("sh", 1'b0, 1'b1);
        chk("sh_b_handshakes", 32'(b_hs), 32'd1);

        // Misaligned SH at offset 3: upper byte falls off, strobe 0x8
        aw_dly = 0; w_dly = 0; b_dly = 2;
        set_store(32'h1000_0007, 32'h0000_1234, 8'h03, 3'd1, 32'h3400_0000, 4'h8);
        run_bus("sh_off3", 1'b0, 1'b1);

        // Load and store requested in the same cycle: store first
        ar_dly = 0; r_dly = 1; aw_dly = 1; w_dly = 0; b_dly = 1;
        set_load(32'h8000_0010, 8'h03, 3'd1, 32'hCAFE_F00D);
        set_store(32'h8000_0020, 32'h55AA_55AA, 8'h0f, 3'd2, 32'h55AA_55AA, 4'hF);
        run_bus("ld_st", 1'b1, 1'b1);
        chk("ld_st_store_first", 32'(wr_cyc < rv_cyc), 32'd1);
        chk("ld_st_bus_err", 32'(bus_err), 32'd0);

        // Load request dropped after capture still completes
        ar_dly = 3; r_dly = 0; drop_r = 1'b1;
        set_load(32'h8000_0100, 8'h01, 3'd0, 32'h0000_005A);
        run_bus("ld_drop", 1'b1, 1'b0);

        // Load with SLVERR sets the sticky error
        ar_dly = 0; r_dly = 0; slv_rresp = 2'd2;
        set_load(32'h8000_0200, 8'h01, 3'd0, 32'h1111_1111);
        run_bus("ld_err", 1'b1, 1'b0);
        chk("ld_err_bus_err", 32'(bus_err), 32'd1);
        slv_rresp = 2'd0;

        // A later OKAY store leaves the error set
        set_store(32'h8000_0300, 32'h0000_0077, 8'h01, 3'd0, 32'h0000_0077, 4'h1);
        run_bus("st_ok", 1'b0, 1'b1);
        chk("sticky_bus_err", 32'(bus_err), 32'd1);

        // Reset in R_R abandons the load and clears everything
        saw_rr = 1'b0;
        lsu_araddr = 32'h8000_0400; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
        for (int c = 0; c < 20 && !saw_rr; c++) begin
            @(negedge clock);
            if (m_rready) saw_rr = 1'b1;
            else m_arready = m_arvalid;
        end
        m_arready = 1'b0;
        chk("reached_r_r", 32'(saw_rr), 32'd1);
        reset = 1'b1;
        lsu_arvalid = 1'b0;
        @(negedge clock);
        chk("mid_reset_ctl", {24'd0, m_arvalid, m_rready, m_awvalid, m_wvalid,
                              m_bready, lsu_rvalid, lsu_wready, bus_err}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        ar_dly = 1; r_dly = 1;
        set_load(32'h8000_0000, 8'h0f, 3'd2, 32'h0BAD_F00D);
        run_bus("lw_after_rst", 1'b1, 1'b0);
        chk("lw_after_rst_err", 32'(bus_err), 32'd0);

        // Store with DECERR sets the sticky error
        aw_dly = 0; w_dly = 0; b_dly = 0; slv_bresp = 2'd3;
        set_store(32'h8000_0501, 32'h0000_00CD, 8'h01, 3'd0, 32'h0000_CD00, 4'h2);
        run_bus("st_err", 1'b0, 1'b1);
        chk("st_err_bus_err", 32'(bus_err), 32'd1);

        chk("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_lsu_axi.md
Name: ysyx_lsu_axi

Overview:
- Downstream of the load/store unit. Converts its level-held load/store requests into single-beat 32-bit AXI4-Lite-style transactions on the data bus.
- Returns `bus_rdata`/`lsu_rvalid` and `lsu_wready` pulses to the LSU.
- Lane-aligns store data and strobes using address bits [1:0]. Loads return raw lane data; the LSU shifts it.
- Orders a store ahead of any load presented in the same or a later cycle.

Parameters:
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- lsu_araddr  in  XLEN  load address
- lsu_arvalid  in  1  load request, held until `lsu_rvalid`
- lsu_rstrb  in  8  load byte mask: 0x01 / 0x03 / 0x0f
- bus_rdata  out  XLEN  load data (raw 32-bit word)
- lsu_rvalid  out  1  one-cycle load-complete pulse
- lsu_awaddr  in  XLEN  store address
- lsu_awvalid  in  1  store address request, held until `lsu_wready`
- lsu_wdata  in  XLEN  store data, right-justified
- lsu_wstrb  in  8  store mask, right-justified: 0x01 / 0x03 / 0x0f
- lsu_wvalid  in  1  store data request, held with `lsu_awvalid`
- lsu_wready  out  1  one-cycle store-complete pulse
- m_araddr  out  XLEN;  m_arsize  out  3;  m_arvalid  out  1;  m_arready  in  1
- m_rdata  in  XLEN;  m_rresp  in  2;  m_rvalid  in  1;  m_rready  out  1
- m_awaddr  out  XLEN;  m_awsize  out  3;  m_awvalid  out  1;  m_awready  in  1
- m_wdata  out  XLEN;  m_wstrb  out  4;  m_wvalid  out  1;  m_wready  in  1
- m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1
- bus_err  out  1  sticky error: set on non-OKAY rresp or bresp; cleared only by reset

Behaviour:
- Reset values:
  - FSMs go to idle.
  - All m_*valid, m_rready, m_bready, `lsu_rvalid`, `lsu_wready` and `bus_err` are 0.
  - `bus_rdata` is 0.
  - Any transaction outstanding at reset is abandoned; the interconnect is reset by the same signal.
- Read FSM, states R_IDLE, R_AR, R_R, R_DONE:
  - R_IDLE → R_AR when `lsu_arvalid` && write FSM is W_IDLE && no store request is present this cycle.
    - Captures `m_araddr` = `lsu_araddr`.
    - `m_arsize` = 0/1/2 for rstrb 0x01/0x03/0x0f; any other value gives size 2.
  - R_AR: `m_arvalid`=1, outputs stable; on `m_arready` go to R_R.
  - R_R: `m_rready`=1; on `m_rvalid`, register `bus_rdata` = `m_rdata`, set `bus_err` if rresp≠0, go to R_DONE.
  - R_DONE: `lsu_rvalid`=1 for exactly this cycle, then R_IDLE.
    - A new read is not accepted in R_DONE.
    - `bus_rdata` holds until the next completion.
- Write FSM, states W_IDLE, W_REQ, W_B, W_DONE:
  - W_IDLE → W_REQ when `lsu_awvalid` && `lsu_wvalid` && read FSM is R_IDLE.
    - If the read FSM is busy, wait until it returns to R_IDLE.
  - Captured values, with off = addr[1:0]:
    - `m_awaddr` = `lsu_awaddr`
    - `m_wdata` = `lsu_wdata` << (8·off)
    - `m_wstrb` = `lsu_wstrb[3:0]` << off, truncated to 4 bits
    - `m_awsize` derived as for reads
  - W_REQ: `m_awvalid` and `m_wvalid` are driven independently.
    - aw_done / w_done flags each drop their valid on its own handshake.
    - Either order is legal, as is both in one cycle.
    - Go to W_B when both are done.
  - W_B: `m_bready`=1; on `m_bvalid`, set `bus_err` if bresp≠0, go to W_DONE.
  - W_DONE: `lsu_wready`=1 for one cycle, then W_IDLE.
- Arbitration and ordering:
  - Read and write never in flight together.
  - Simultaneous new load and store in R_IDLE/W_IDLE: the store wins and the load waits.
- Request drop: a request dropped by the LSU after capture still completes on the bus; the completion pulse is still issued.
- Misaligned halfword at off=3 is not detected; strobe truncates to 0x8.

Decomposition:
- Shared package/header (ysyx.svh): read and write FSM state enums; AXI resp constants OKAY=0, SLVERR=2, DECERR=3; helper function strb→size.
- One natural sub-module, `ysyx_lsu_axi_walign`: combinational data/strobe lane shifter.
- FSMs stay in the top module.

Test Plan:
- LW at 0x80000000: arready delayed 2 cycles, rvalid 3 cycles after AR with rdata 0xDEADBEEF → arsize=2, one AR handshake only, `lsu_rvalid` single pulse, `bus_rdata`=0xDEADBEEF.
- SB addr 0x80000003, wdata 0x000000AB, wstrb 0x01 → awsize=0, `m_wdata`=0xAB000000, `m_wstrb`=0x8; `lsu_wready` pulses 1 cycle after bvalid.
- SH addr 0x0F000002, wdata 0x00001234, wstrb 0x03; wready asserted 2 cycles before awready → `m_wdata`=0x12340000, `m_wstrb`=0xC; each valid drops after its own handshake; single B accepted.
- Load and store asserted in the same cycle → store completes first (`lsu_wready`), then AR issues; no overlap of `m_arvalid` with W_REQ/W_B.
- Load with rresp=2, rdata 0x11111111 → `lsu_rvalid` pulses, `bus_rdata`=0x11111111, `bus_err`=1 and remains 1 after a later OKAY access.
- Reset asserted in R_R → next cycle all valids/readies are 0 and `bus_err` is 0; a later LW completes normally.
